// File: rtl/signmag_bcd_scheduler.sv
// signmag_bcd_scheduler: round-robin signed-to-sign/magnitude BCD converter with valid/ready output
module signmag_bcd_scheduler #(
  parameter int BITS = 8,
  parameter int NREQ = 2,
  parameter int DIGITS = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*(BITS+1)-1:0]   value,
  output logic [NREQ-1:0]            grant,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sign,
  output logic [4*DIGITS-1:0]        out_bcd,
  output logic [$clog2(NREQ)-1:0]    out_src
);
  localparam int W = BITS + 1;
  localparam int BW = 4 * DIGITS;
  localparam int SW = $clog2(NREQ);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(BITS);
  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
  state_t state, state_n;
  logic [SW-1:0] ptr, win;
  logic [CW-1:0] cnt;
  logic [BW+W-1:0] sh, adj, shn;
  logic [W-1:0] cap, mag;
  logic found, take, last, bubble, sgn;
  always_comb begin
    win = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        win = SW'((int'(ptr) + k) % NREQ);
      end
    end
  end
  assign take = !rst && state == IDLE && !bubble && found;
  assign grant = take ? NREQ'(1'b1) << win : '0;
  assign cap = value[int'(win)*W +: W];
  assign mag = cap[W-1] ? -cap : cap;
  assign busy = state != IDLE;
  assign out_valid = state == DONE;
  assign last = cnt == LAST;
  assign adj[W-1:0] = sh[W-1:0];
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign adj[W+4*d +: 4] = sh[W+4*d +: 4] >= 4'd5 ? sh[W+4*d +: 4] + 4'd3 : sh[W+4*d +: 4];
  end
  assign shn = adj << 1;
  always_comb begin
    state_n = state == IDLE    ? (take ? CONVERT : IDLE) :
              state == CONVERT ? (last ? DONE : CONVERT) :
                                 (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      sh <= '0;
      sgn <= 1'b0;
      bubble <= 1'b0;
      out_sign <= 1'b0;
      out_bcd <= '0;
      out_src <= '0;
    end else begin
      state <= state_n;
      bubble <= state == DONE && out_ready;
      if (take) begin
        sgn <= cap[W-1];
        sh <= {{BW{1'b0}}, mag};
        cnt <= '0;
        out_src <= win;
        ptr <= win == SW'(NREQ - 1) ? '0 : win + 1'b1;
      end
      if (state == CONVERT) begin
        sh <= shn;
        cnt <= cnt + 1'b1;
        if (last) begin
          out_bcd <= shn[BW+W-1:W];
          out_sign <= sgn;
        end
      end
    end
  end
endmodule

// File: doc/signmag_bcd_scheduler.md
Name: signmag_bcd_scheduler

Overview:
- Shared converter and scheduler for signed results going to the display path.
- Takes up to NREQ requesters, each presenting a (BITS+1)-bit two's-complement value, and arbitrates them round-robin.
- Converts the granted value to sign plus magnitude, then to packed BCD using a sequential shift-add-3 (double-dabble) engine.
- Presents the result on a valid/ready output toward the display driver.

Parameters:
- BITS, 8, magnitude width; inputs are BITS+1 bits signed.
- NREQ, 2, number of requesters (>=2).
- DIGITS, 3, BCD output digits; must satisfy 10^DIGITS > 2^BITS (integrator's responsibility, not checked).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level; held until its grant bit pulses.
- value  in  NREQ*(BITS+1)  packed two's-complement values; requester i occupies bits [i*(BITS+1) +: BITS+1]; held stable while req[i]=1.
- grant  out  NREQ  one-hot, one-cycle pulse in the capture cycle.
- busy  out  1  high whenever state is not IDLE.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_sign  out  1  1 = negative.
- out_bcd  out  4*DIGITS  packed BCD, digit 0 = LSD at bits [3:0].
- out_src  out  clog2(NREQ)  index of the requester that produced the result.

Behaviour:
- Reset:
  - grant, busy, out_valid, out_sign, out_bcd and out_src all 0.
  - State is IDLE; round-robin pointer is 0, so requester 0 has highest priority.
- States: IDLE -> CONVERT -> DONE -> IDLE.
- IDLE:
  - If any req bit is set, grant the first set bit at or after the pointer, wrapping modulo NREQ.
  - In the same cycle: pulse grant, capture value, set out_src, update the pointer to winner+1 (mod NREQ), go to CONVERT.
  - req is sampled only in IDLE; requests raised in any other state wait.
- Sign/magnitude:
  - sign = MSB of the captured value.
  - magnitude = captured value if sign=0, else its two's-complement negation, computed BITS+1 wide.
  - -2^BITS (for example 9'h100) therefore yields magnitude 2^BITS exactly, with no saturation or wrap.
  - Zero yields sign 0.
- CONVERT:
  - Runs exactly BITS+1 iterations, one per cycle.
  - Each iteration: add 3 to every BCD digit >= 5, then shift {bcd, mag} left by 1.
  - An iteration counter clears on entry; after the last iteration, go to DONE.
- DONE:
  - out_valid=1; out_sign, out_bcd and out_src are stable.
  - out_valid=1 and out_ready=1 in the same cycle is the handshake: out_valid drops next cycle and state returns to IDLE.
  - Next grant comes no earlier than the cycle after that (one-cycle bubble).
  - out_ready while out_valid=0 is ignored.
- Latency: grant at cycle T -> out_valid first high at T+BITS+2 (T+10 for BITS=8).
- out_bcd and out_sign hold the last result after the handshake until overwritten on the next DONE entry; consumers qualify them with out_valid.
- rst mid-operation (any state):
  - The in-flight conversion is dropped with no handshake.
  - Next cycle, all outputs are at reset values and the pointer is 0.
- Requester dropping req before its grant: legal; it is simply not granted.
- Requester dropping req after its grant: no effect on the in-flight conversion.

Test Plan:
- BITS=8, DIGITS=3, NREQ=2. Only req[0]=1 with value0=9'h07F (+127), out_ready=1 -> grant=2'b01 for one cycle; out_valid at grant+10; out_sign=0, out_bcd=12'h127, out_src=0; out_valid low the following cycle.
- value0=9'h1FF (-1) -> out_sign=1, out_bcd=12'h001. Then value0=9'h100 (-256) -> out_sign=1, out_bcd=12'h256. Then value0=9'h000 -> out_sign=0, out_bcd=12'h000.
- req=2'b11 held continuously, value0=9'h00A, value1=9'h1F6 -> grants in order 0,1,0,1; results alternate (sign0, 010, src0) and (sign1, 010, src1); consecutive grants are 12 cycles apart with out_ready=1.
- out_ready=0 for 5 cycles after out_valid rises, with req[1] asserted meanwhile -> out_valid, out_bcd and out_src stable for all 5 cycles, no grant pulse; raising out_ready -> handshake, then grant=2'b10 two cycles later.
- rst=1 for one cycle at the 4th CONVERT cycle -> next cycle busy=0, out_valid=0, out_bcd=0, out_sign=0; with req=2'b11 afterwards, the first grant goes to requester 0.
- value0=9'h0FF (+255) -> out_bcd=12'h255; value0=9'h101 (-255) -> out_sign=1, out_bcd=12'h255.
